magnitude_seq: RTL and testbench

Clocked, parametrised gradient-magnitude unit for the Sobel filter path. It takes one signed (Gx, Gy) pair per transaction and returns either the exact floor(sqrt(Gx²+Gy²)) or the fast |Gx|+|Gy| approximation, saturated to the pixel output width. It uses a valid/ready handshake on both sides. It replaces the edge-triggered, combinational-loop magnitude block with a single-clock, multi-cycle digit-by-digit square root.

---
 rtl/magnitude_seq_pkg.sv | 15 +
 rtl/magnitude_seq_if.sv | 26 ++
 rtl/magnitude_seq_isqrt_step.sv | 23 ++
 rtl/magnitude_seq.sv | 127 ++++++++++++
 tb/tb_magnitude_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/magnitude_seq_pkg.sv
// Shared types and constants for the gradient-magnitude unit.
// Holds the FSM state encoding and the magnitude mode selectors.
package mag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ROOT   = 2'd2,
        DONE   = 2'd3
    } mag_state_t;

    localparam logic MAG_MODE_L2 = 1'b0;
    localparam logic MAG_MODE_L1 = 1'b1;

endpackage

// File: rtl/magnitude_seq_if.sv
// Handshake bundle for magnitude_seq: gradient pair in, saturated magnitude out.
// The master drives gradients and accepts results; the slave is the unit.
interface magnitude_seq_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  gx;
    logic signed [IN_W-1:0]  gy;
    logic                    mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        mag;
    logic                    sat;

    modport master (
        output in_valid, gx, gy, mode, out_ready,
        input  in_ready, out_valid, mag, sat
    );

    modport slave (
        input  in_valid, gx, gy, mode, out_ready,
        output in_ready, out_valid, mag, sat
    );
endinterface

// File: rtl/magnitude_seq_isqrt_step.sv
// One iteration of a restoring digit-by-digit square root: brings in two
// radicand bits, tries (root<<2)|1 against the remainder, emits one root bit.
module isqrt_step #(
    parameter int ROOT_W = 11
) (
    input  logic [ROOT_W+1:0] rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        bits,
    output logic [ROOT_W+1:0] rem_next,
    output logic [ROOT_W-1:0] root_next
);
    logic [ROOT_W+3:0] shifted;
    logic [ROOT_W+3:0] trial;
    logic              take;

    assign shifted = {rem, bits};
    assign trial   = {2'b00, root, 2'b01};
    assign take    = (shifted >= trial);

    // The remainder never exceeds 2*root, so dropping the top two bits is lossless.
    assign rem_next  = take ? (ROOT_W+2)'(shifted - trial) : (ROOT_W+2)'(shifted);
    assign root_next = {root[ROOT_W-2:0], take};
endmodule

// File: rtl/magnitude_seq.sv
// Multi-cycle gradient magnitude: exact floor(sqrt(gx^2+gy^2)) or |gx|+|gy|,
// saturated to OUT_W bits, with valid/ready handshakes on both sides.
module magnitude_seq
    import mag_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    magnitude_seq_if.slave bus
);
    localparam int SQ_W   = 2 * IN_W;
    localparam int ROOT_W = IN_W;
    localparam int REM_W  = ROOT_W + 2;
    localparam int RAW_W  = IN_W + 1;
    localparam int CNT_W  = $clog2(ROOT_W);
    localparam logic [31:0] SAT_MAX = (32'd1 << OUT_W) - 32'd1;

    mag_state_t              state_reg;
    logic signed [IN_W-1:0]  gx_reg;
    logic signed [IN_W-1:0]  gy_reg;
    logic                    mode_reg;
    logic [SQ_W-1:0]         rad_reg;
    logic [REM_W-1:0]        rem_reg;
    logic [ROOT_W-1:0]       root_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [OUT_W-1:0]        mag_reg;
    logic                    sat_reg;
    logic                    out_valid_reg;

    logic [IN_W-1:0]   gx_u, gy_u, abs_gx, abs_gy;
    logic [SQ_W-1:0]   sq_sum;
    logic [RAW_W-1:0]  l1_sum, raw_next;
    logic [REM_W-1:0]  rem_next;
    logic [ROOT_W-1:0] root_next;
    logic              sat_next;
    logic [OUT_W-1:0]  mag_next;

    // Unsigned IN_W-bit absolute value keeps |-2^(IN_W-1)| exact.
    assign gx_u   = gx_reg;
    assign gy_u   = gy_reg;
    assign abs_gx = gx_u[IN_W-1] ? (~gx_u + 1'b1) : gx_u;
    assign abs_gy = gy_u[IN_W-1] ? (~gy_u + 1'b1) : gy_u;
    assign sq_sum = SQ_W'(abs_gx) * SQ_W'(abs_gx) + SQ_W'(abs_gy) * SQ_W'(abs_gy);
    assign l1_sum = RAW_W'(abs_gx) + RAW_W'(abs_gy);

    isqrt_step #(.ROOT_W(ROOT_W)) u_step (
        .rem       (rem_reg),
        .root      (root_reg),
        .bits      (rad_reg[SQ_W-1 -: 2]),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    // Raw result at the moment of entering DONE, from either path.
    assign raw_next = (state_reg == SQUARE) ? l1_sum : RAW_W'(root_next);
    assign sat_next = (32'(raw_next) > SAT_MAX);
    assign mag_next = sat_next ? {OUT_W{1'b1}} : OUT_W'(raw_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gx_reg        <= '0;
            gy_reg        <= '0;
            mode_reg      <= MAG_MODE_L2;
            rad_reg       <= '0;
            rem_reg       <= '0;
            root_reg      <= '0;
            cnt_reg       <= '0;
            mag_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        gx_reg    <= bus.gx;
                        gy_reg    <= bus.gy;
                        mode_reg  <= bus.mode;
                        state_reg <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (mode_reg == MAG_MODE_L1) begin
                        mag_reg   <= mag_next;
                        sat_reg   <= sat_next;
                        state_reg <= DONE;
                    end else begin
                        rad_reg   <= sq_sum;
                        rem_reg   <= '0;
                        root_reg  <= '0;
                        cnt_reg   <= CNT_W'(ROOT_W - 1);
                        state_reg <= ROOT;
                    end
                end
                ROOT: begin
                    rad_reg  <= rad_reg << 2;
                    rem_reg  <= rem_next;
                    root_reg <= root_next;
                    if (cnt_reg == '0) begin
                        mag_reg   <= mag_next;
                        sat_reg   <= sat_next;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    // Result is presented one cycle after it is latched.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.mag       = mag_reg;
    assign bus.sat       = sat_reg;
endmodule

// File: tb/tb_magnitude_seq.sv
// Directed bench for magnitude_seq: hand-computed magnitudes, latencies,
// back-pressure and mid-transaction reset.
module tb_magnitude_seq;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    magnitude_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    magnitude_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_accept(input string tag, input int gx, input int gy, input logic mode);
        @(negedge clk);
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.gx       = IN_W'(gx);
        bus.gy       = IN_W'(gy);
        bus.mode     = mode;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Entered just after the accept edge; counts edges until out_valid.
    task automatic wait_result(input string tag, input int exp_mag, input int exp_sat, input int exp_lat);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_mag"}, 32'(bus.mag), 32'(exp_mag));
        check_val({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
        check_val({tag, "_busy"}, 32'(bus.in_ready), 0);
        $display("txn %s: mag=%0d sat=%0d latency=%0d", tag, bus.mag, bus.sat, lat);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        check_val({tag, "_ready_back"}, 32'(bus.in_ready), 1);
    endtask

    task automatic run_txn(input string tag, input int gx, input int gy, input logic mode,
                           input int exp_mag, input int exp_sat);
        drive_accept(tag, gx, gy, mode);
        wait_result(tag, exp_mag, exp_sat, (mode == 1'b1) ? 2 : IN_W + 2);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.gx        = '0;
        bus.gy        = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check_val("reset_out_valid", 32'(bus.out_valid), 0);
        check_val("reset_mag", 32'(bus.mag), 0);
        check_val("reset_sat", 32'(bus.sat), 0);
        check_val("reset_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("l2_3_4",       3,     4,     1'b0,   5, 0);
        run_txn("l2_min_min",   -1024, -1024, 1'b0, 255, 1);
        run_txn("l2_100_m100",  100,   -100,  1'b0, 141, 0);
        run_txn("l1_100_m100",  100,   -100,  1'b1, 200, 0);
        run_txn("l2_zero",      0,     0,     1'b0,   0, 0);
        run_txn("l1_zero",      0,     0,     1'b1,   0, 0);
        run_txn("l1_255_edge",  255,   0,     1'b1, 255, 0);
        run_txn("l1_256_sat",   128,   128,   1'b1, 255, 1);
        run_txn("l1_max",       1023,  -1024, 1'b1, 255, 1);
        run_txn("l2_150_200",   150,   200,   1'b0, 250, 0);

        // Back-pressure: result must hold while in_valid pulses are ignored.
        drive_accept("bp", 5, -7, 1'b1);
        wait_result("bp", 12, 0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.gx       = IN_W'(i * 10 + 1);
            bus.mode     = 1'b0;
            @(posedge clk);
            #1;
            check_val("bp_hold_valid", 32'(bus.out_valid), 1);
            check_val("bp_hold_mag", 32'(bus.mag), 12);
            check_val("bp_hold_sat", 32'(bus.sat), 0);
            check_val("bp_hold_in_ready", 32'(bus.in_ready), 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.gx        = IN_W'(1);
        bus.gy        = IN_W'(2);
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("bp_release_valid", 32'(bus.out_valid), 0);
        check_val("bp_release_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val("bp_next_accepted", 32'(bus.in_ready), 0);
        wait_result("bp_next", 3, 0, 2);
        handshake("bp_next");

        // Reset during ROOT aborts the transaction and clears the outputs.
        drive_accept("rst_abort", 150, 200, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check_val("rst_pre_busy", 32'(bus.in_ready), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(bus.out_valid), 0);
        check_val("rst_mag", 32'(bus.mag), 0);
        check_val("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post_rst_6_8", 6, 8, 1'b0, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
